// File: rtl/vga_fb_scheduler.sv
// Framebuffer port scheduler: display fetch owns the single-port RAM during vidon,
// host pixel writes queue in a small FIFO and drain during blanking.
module vga_fb_scheduler #(
    parameter logic [9:0] H_START    = 10'd145,
    parameter logic [9:0] V_START    = 10'd32,
    parameter logic [9:0] H_ACTIVE   = 10'd640,
    parameter int         FIFO_DEPTH = 4,
    parameter int         AW         = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    hc,
    input  logic [9:0]    vc,
    input  logic          vidon,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    pix,
    output logic          pix_valid,
    output logic          frame_start,
    output logic          ovf
);

    localparam int          DATA_W  = 8;
    localparam int          PW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    // Constant-coefficient shift-add: for 640 this folds to (y<<9)+(y<<7)+x.
    function automatic logic [AW-1:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
        logic [AW-1:0] acc;
        acc = AW'(x);
        for (int b = 0; b < 10; b++) begin
            if (H_ACTIVE[b]) acc = acc + (AW'(y) << b);
        end
        return acc;
    endfunction

    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;
    logic [AW-1:0]     r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic              r_ovf;

    logic [AW-1:0]     r_mem_addr_p0;
    logic              r_mem_we_p0;
    logic [DATA_W-1:0] r_mem_wdata_p0;
    logic              r_vld_p0;
    logic              r_vld_p1;
    logic              r_vld_p2;
    logic [DATA_W-1:0] r_pix_p2;
    logic              r_frame_start;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [AW-1:0]     w_nxt_addr;
    logic              w_nxt_we;
    logic [DATA_W-1:0] w_nxt_wdata;

    always_comb begin
        w_full      = (r_count == DEPTH_C);
        w_empty     = (r_count == '0);
        w_push      = wr_valid && !w_full;
        w_pop       = !vidon && !w_empty;
        w_nxt_addr  = r_mem_addr_p0;
        w_nxt_we    = 1'b0;
        w_nxt_wdata = r_mem_wdata_p0;
        if (vidon) begin
            w_nxt_addr = lin_addr(hc - H_START, vc - V_START);
        end else if (w_pop) begin
            w_nxt_addr  = r_fifo_addr[r_rptr];
            w_nxt_wdata = r_fifo_data[r_rptr];
            w_nxt_we    = 1'b1;
        end
    end

    // FIFO storage carries data only; emptiness is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= wr_addr;
            r_fifo_data[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
            if (wr_valid && w_full) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr_p0  <= '0;
            r_mem_we_p0    <= 1'b0;
            r_mem_wdata_p0 <= '0;
            r_vld_p0       <= 1'b0;
            r_vld_p1       <= 1'b0;
            r_vld_p2       <= 1'b0;
            r_pix_p2       <= '0;
            r_frame_start  <= 1'b0;
        end else begin
            // p0: request presented to the RAM
            r_mem_addr_p0  <= w_nxt_addr;
            r_mem_we_p0    <= w_nxt_we;
            r_mem_wdata_p0 <= w_nxt_wdata;
            r_vld_p0       <= vidon;
            // p1: RAM read data in flight
            r_vld_p1       <= r_vld_p0;
            // p2: pixel registered for the DAC
            r_vld_p2       <= r_vld_p1;
            r_pix_p2       <= r_vld_p1 ? mem_rdata : '0;
            r_frame_start  <= (hc == 10'd0) && (vc == 10'd0);
        end
    end

    assign wr_ready    = !w_full;
    assign mem_addr    = r_mem_addr_p0;
    assign mem_we      = r_mem_we_p0;
    assign mem_wdata   = r_mem_wdata_p0;
    assign pix         = r_pix_p2;
    assign pix_valid   = r_vld_p2;
    assign frame_start = r_frame_start;
    assign ovf         = r_ovf;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler with a registered-read RAM model.
module tb_vga_fb_scheduler;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic          vidon;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [7:0]    pix;
    logic          pix_valid;
    logic          frame_start;
    logic          ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        ld_en;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  ram [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en)       ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[11:0]];
    end

    vga_fb_scheduler dut (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc), .vidon(vidon),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix(pix), .pix_valid(pix_valid), .frame_start(frame_start), .ovf(ovf)
    );

    function automatic logic [7:0] pat(input int a);
        if (a == 0) return 8'h5C;
        return 8'((a * 37) ^ (a >> 4));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hc = 10'd799; vc = 10'd524; vidon = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; ld_en = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            ld_addr = 12'(i); ld_data = pat(i);
            step();
        end
        ld_en = 1'b0;
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
        n_cmp++; if ({pix, pix_valid} !== 9'h0) begin n_fail++; $display("FAIL reset_pix: got %h/%b want 00/0", pix, pix_valid); end
        n_cmp++; if ({frame_start, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got fs=%b ovf=%b want 0/0", frame_start, ovf); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_addr();
        hc = 10'd145; vc = 10'd32; vidon = 1'b1;
        step();
        n_cmp++; if ({mem_we, mem_addr} !== {1'b0, 19'd0}) begin n_fail++; $display("FAIL addr_origin: got we=%b addr=%0d want we=0 addr=0", mem_we, mem_addr); end
        hc = 10'd155; vc = 10'd35;
        step();
        n_cmp++; if (mem_addr !== 19'd1930) begin n_fail++; $display("FAIL addr_1930: got %0d want 1930", mem_addr); end
        hc = 10'd790; vidon = 1'b0;
        step();
        n_cmp++; if (mem_addr !== 19'd1930) begin n_fail++; $display("FAIL addr_hold: got %0d want 1930", mem_addr); end
        n_cmp++; if ({pix_valid, pix} !== {1'b1, 8'h5C}) begin n_fail++; $display("FAIL pix_first: got %b/%h want 1/5c", pix_valid, pix); end
        step();
        n_cmp++; if ({pix_valid, pix} !== {1'b1, pat(1930)}) begin n_fail++; $display("FAIL pix_1930: got %b/%h want 1/%h", pix_valid, pix, pat(1930)); end
        step();
        n_cmp++; if ({pix_valid, pix} !== 9'h0) begin n_fail++; $display("FAIL pix_blank: got %b/%h want 0/00", pix_valid, pix); end
    endtask

    task automatic test_frame();
        logic vq [3];
        int   aq [3];
        int   err_addr = 0, err_pix = 0, n_pv = 0, n_we = 0, n_fs = 0;
        logic fs_ok = 1'b0;
        logic vid;
        int   a;
        for (int k = 0; k < 3; k++) begin vq[k] = 1'b0; aq[k] = 0; end
        for (int v = 0; v < 40; v++) begin
            for (int h = 0; h < 800; h++) begin
                vid = (h >= 145) && (h < 785) && (v >= 32) && (v < 36);
                a   = vid ? ((v - 32) * 640 + (h - 145)) : 0;
                hc = 10'(h); vc = 10'(v); vidon = vid;
                step();
                if (vid && (mem_addr !== AW'(a))) err_addr++;
                if (mem_we === 1'b1) n_we++;
                vq[2] = vq[1]; vq[1] = vq[0]; vq[0] = vid;
                aq[2] = aq[1]; aq[1] = aq[0]; aq[0] = a;
                if ((pix_valid !== vq[2]) || (pix !== (vq[2] ? pat(aq[2]) : 8'h00))) err_pix++;
                if (pix_valid === 1'b1) n_pv++;
                if (frame_start === 1'b1) begin
                    n_fs++;
                    if (v == 0 && h == 0) fs_ok = 1'b1;
                end
            end
        end
        hc = 10'd790; vidon = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (pix_valid === 1'b1) n_pv++;
        end
        n_cmp++; if (err_addr != 0) begin n_fail++; $display("FAIL frame_addr: got %0d bad cycles want 0", err_addr); end
        n_cmp++; if (err_pix != 0) begin n_fail++; $display("FAIL frame_pix: got %0d bad cycles want 0", err_pix); end
        n_cmp++; if (n_pv != 2560) begin n_fail++; $display("FAIL frame_pv_count: got %0d want 2560", n_pv); end
        n_cmp++; if (n_we != 0) begin n_fail++; $display("FAIL frame_no_we: got %0d want 0", n_we); end
        n_cmp++; if (n_fs != 1 || fs_ok !== 1'b1) begin n_fail++; $display("FAIL frame_start: got %0d pulses at_origin=%b want 1/1", n_fs, fs_ok); end
    endtask

    task automatic test_three_writes();
        int n_we = 0;
        hc = 10'd300; vc = 10'd100; vidon = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 8'hA1 + 8'(i);
            n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL tw_ready%0d: got %b want 1", i, wr_ready); end
            step();
            if (mem_we !== 1'b0) n_we++;
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (mem_we !== 1'b0) n_we++;
        end
        n_cmp++; if (n_we != 0) begin n_fail++; $display("FAIL tw_no_we_vidon: got %0d want 0", n_we); end
        hc = 10'd790; vidon = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(i), 8'hA1 + 8'(i)}) begin
                n_fail++; $display("FAIL tw_write%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, i, 8'hA1 + 8'(i));
            end
        end
        step();
        n_cmp++; if ({mem_we, wr_ready} !== 2'b01) begin n_fail++; $display("FAIL tw_empty: got we=%b rdy=%b want 0/1", mem_we, wr_ready); end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] ea;
        hc = 10'd300; vc = 10'd100; vidon = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(100 + i); wr_data = 8'h10 + 8'(i);
            n_cmp++; if (wr_ready !== (i < 4)) begin n_fail++; $display("FAIL ov_ready%0d: got %b want %b", i, wr_ready, (i < 4)); end
            step();
            if (i == 3) begin
                n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ov_before: got %b want 0", ovf); end
            end
        end
        wr_valid = 1'b0;
        n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ov_set: got %b want 1", ovf); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                hc = 10'd300; vidon = 1'b1;
                step();
                n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ov_vidon_hold: got we=%b want 0", mem_we); end
            end
            hc = 10'd790; vidon = 1'b0;
            step();
            ea = AW'(100 + i);
            n_cmp++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ea, 8'h10 + 8'(i)}) begin
                n_fail++; $display("FAIL ov_write%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, ea, 8'h10 + 8'(i));
            end
        end
        step();
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ov_fifth_dropped: got we=%b want 0", mem_we); end
    endtask

    task automatic test_full_simul();
        rst = 1'b1;
        #1;
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fs_ovf_cleared: got %b want 0", ovf); end
        step();
        rst = 1'b0;
        hc = 10'd300; vc = 10'd100; vidon = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(200 + i); wr_data = 8'h20 + 8'(i);
            step();
        end
        wr_addr = AW'(204); wr_data = 8'h24; hc = 10'd790; vidon = 1'b0;
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fs_ready_full: got %b want 0", wr_ready); end
        step();
        wr_valid = 1'b0;
        n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL fs_ovf: got %b want 1", ovf); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_cmp++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(200 + i), 8'h20 + 8'(i)}) begin
                n_fail++; $display("FAIL fs_pop%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, 200 + i, 8'h20 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_we = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        hc = 10'd300; vc = 10'd100; vidon = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(300 + i); wr_data = 8'h30 + 8'(i);
            step();
        end
        wr_valid = 1'b0;
        step();
        n_cmp++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_valid: got %b want 1", pix_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({pix_valid, pix, mem_we, mem_addr} !== {1'b0, 8'h00, 1'b0, 19'd0}) begin
            n_fail++; $display("FAIL rm_async: got pv=%b pix=%h we=%b addr=%0d want 0/00/0/0", pix_valid, pix, mem_we, mem_addr);
        end
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b want 1", wr_ready); end
        step();
        rst = 1'b0;
        hc = 10'd790; vidon = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_we !== 1'b0 || pix_valid !== 1'b0) n_we++;
        end
        n_cmp++; if (n_we != 0) begin n_fail++; $display("FAIL rm_stale: got %0d bad cycles want 0", n_we); end
        wr_valid = 1'b1; wr_addr = AW'(400); wr_data = 8'h77;
        step();
        wr_valid = 1'b0;
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 19'd400, 8'h77}) begin
            n_fail++; $display("FAIL rm_first_write: got we=%b addr=%0d data=%h want 1/400/77", mem_we, mem_addr, mem_wdata);
        end
        step();
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rm_only_one: got we=%b want 0", mem_we); end
        hc = 10'd300; vidon = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL rm_resume: got %b want 1", pix_valid); end
    endtask

    initial begin
        test_reset();
        test_addr();
        test_frame();
        test_three_writes();
        test_overflow();
        test_full_simul();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
